// File: rtl/data_mem_wait.sv
// Data-memory responder for the CPU MEM stage: services byte-masked word
// reads/writes after WaitCycles stall cycles, then pulses ack for one cycle.
module data_mem_wait #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int DepthLog2  = 10,
  parameter int WaitCycles = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 re,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [3:0]           byte_slct,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 stall_o,
  output logic                 ack_o,
  output logic                 busy_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int         Depth   = 1 << DepthLog2;
  localparam logic [3:0] CntLoad = 4'(WaitCycles - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   accept, done;
  logic [DepthLog2-1:0]   idx_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [3:0]             slct_q;
  logic                   is_write_q;
  logic [DataWidth-1:0]   mem [Depth];

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{addr_i[AddrWidth-1:DepthLog2+2], addr_i[1:0]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (re || we) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = CntLoad;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && accept) begin
      idx_q      <= addr_i[DepthLog2+1:2];
      wdata_q    <= data_i;
      slct_q     <= byte_slct;
      is_write_q <= we;
    end
  end

  // NOTE: the RAM array has no reset; it maps onto block RAM and contents are
  // undefined after power-up. A reset at the closing edge discards the write.
  always_ff @(posedge clk) begin
    if (rst && done && is_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (slct_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign stall_o = rst && (((state_q == IDLE) && (re || we)) ||
                           ((state_q == BUSY) && (cnt_q != 4'd0)));
  assign ack_o   = rst && done;
  assign busy_o  = rst && (state_q == BUSY);
  assign data_o  = (rst && done && !is_write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_data_mem_wait.sv
// Self-checking bench for data_mem_wait: transaction-age model compared every
// cycle, plus directed transactions with hand-computed literal expectations.
module tb_data_mem_wait;

  localparam int WAIT  = 2;
  localparam int DLOG2 = 10;

  logic        clk = 1'b0;
  logic        rst, re, we;
  logic [31:0] addr_i, data_i, data_o;
  logic [3:0]  byte_slct;
  logic        stall_o, ack_o, busy_o;

  int checks   = 0;
  int failures = 0;

  data_mem_wait #(.DataWidth(32), .AddrWidth(32), .DepthLog2(DLOG2), .WaitCycles(WAIT)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr_i(addr_i), .byte_slct(byte_slct),
    .data_i(data_i), .data_o(data_o), .stall_o(stall_o), .ack_o(ack_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a transaction is described by its age in cycles since the request
  // was first seen; completion happens at age WAIT.
  logic [31:0] mem_m [int];
  bit          m_active = 1'b0;
  int          m_age;
  bit          m_write;
  int          m_idx;
  logic [31:0] m_data;
  logic [3:0]  m_slct;
  bit          model_run = 1'b1;

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << DLOG2) - 32'd1));
  endfunction

  initial begin
    @(posedge clk);
    while (model_run) begin
      @(negedge clk);
      if (!rst) begin
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_ack",   {31'd0, ack_o},   32'd0);
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        check("rst_data",  data_o,           32'd0);
      end else if (!m_active) begin
        check("idle_stall", {31'd0, stall_o}, {31'd0, re | we});
        check("idle_ack",   {31'd0, ack_o},   32'd0);
        check("idle_busy",  {31'd0, busy_o},  32'd0);
        check("idle_data",  data_o,           32'd0);
      end else begin
        check("busy_stall", {31'd0, stall_o}, {31'd0, m_age < WAIT});
        check("busy_ack",   {31'd0, ack_o},   {31'd0, m_age == WAIT});
        check("busy_busy",  {31'd0, busy_o},  32'd1);
        if (m_age == WAIT && !m_write) begin
          if (mem_m.exists(m_idx)) check("rd_data", data_o, mem_m[m_idx]);
        end else begin
          check("busy_data", data_o, 32'd0);
        end
      end
      @(posedge clk);
      if (!rst) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (re || we) begin
          m_active = 1'b1;
          m_age    = 1;
          m_write  = we;
          m_idx    = word_idx(addr_i);
          m_data   = data_i;
          m_slct   = byte_slct;
        end
      end else if (m_age == WAIT) begin
        m_active = 1'b0;
        if (m_write) begin
          if (m_slct == 4'hF) mem_m[m_idx] = m_data;
          else if (mem_m.exists(m_idx))
            for (int i = 0; i < 4; i++)
              if (m_slct[i]) mem_m[m_idx][8*i +: 8] = m_data[8*i +: 8];
        end
      end else begin
        m_age++;
      end
    end
  end

  // Issues one access (caller is just after a rising edge), waits for ack with
  // a bounded budget, reports stall-cycle count, ack-cycle data and ack time.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit drop,
                        output int stalls, output logic [31:0] rd, output time t_ack);
    bit got = 1'b0;
    re = r; we = w; addr_i = a; data_i = d; byte_slct = s;
    stalls = 0; rd = 'x; t_ack = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack_o) begin
        got = 1'b1; rd = data_o; t_ack = $time;
      end else if (stall_o) begin
        stalls++;
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (drop) begin re = 1'b0; we = 1'b0; end
  endtask

  int          st;
  logic [31:0] rd;
  time         t0, t1, t2;

  initial begin
    rst = 1'b0; re = 1'b1; we = 1'b0; addr_i = 32'h10; data_i = '0; byte_slct = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy_lit", {31'd0, busy_o}, 32'd0);
    check("reset_stall_lit", {31'd0, stall_o}, 32'd0);
    re = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Word write then read
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, st, rd, t0);
    check("wr_stalls_lit", st, WAIT);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, st, rd, t0);
    check("rd_stalls_lit", st, WAIT);
    check("rd_word_lit", rd, 32'hDEADBEEF);

    // Byte lanes and an empty mask
    access(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b1, st, rd, t0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, st, rd, t0);
    check("lane_lit", rd, 32'hDEADAAEF);
    access(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1, st, rd, t0);
    check("slct0_stalls_lit", st, WAIT);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, st, rd, t0);
    check("slct0_lit", rd, 32'hDEADAAEF);

    // Held re across three reads
    access(1'b0, 1'b1, 32'h14, 32'h11111111, 4'hF, 1'b1, st, rd, t0);
    access(1'b0, 1'b1, 32'h18, 32'h22222222, 4'hF, 1'b1, st, rd, t0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, st, rd, t0);
    check("held0_lit", rd, 32'hDEADAAEF);
    access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, st, rd, t1);
    check("held1_lit", rd, 32'h11111111);
    access(1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b1, st, rd, t2);
    check("held2_lit", rd, 32'h22222222);
    check("held_gap1", 32'(t1 - t0), 32'((WAIT + 1) * 10));
    check("held_gap2", 32'(t2 - t1), 32'((WAIT + 1) * 10));

    // Reset during the first BUSY cycle discards the write
    access(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b1, st, rd, t0);
    re = 1'b0; we = 1'b1; addr_i = 32'h20; data_i = 32'h12345678; byte_slct = 4'hF;
    @(posedge clk); #1;
    check("first_busy_lit", {31'd0, busy_o}, 32'd1);
    rst = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busy_lit", {31'd0, busy_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, st, rd, t0);
    check("rst_mid_lit", rd, 32'h00000000);

    // Aliasing and read/write conflict
    access(1'b1, 1'b0, 32'h1010, 32'h0, 4'h0, 1'b1, st, rd, t0);
    check("alias_lit", rd, 32'hDEADAAEF);
    access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b1, st, rd, t0);
    check("conflict_data_lit", rd, 32'h0);
    access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, st, rd, t0);
    check("conflict_rd_lit", rd, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    model_run = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_wait.md
# data_mem_wait

Data-memory responder for the pipelined CPU's MEM-stage data port. It accepts the CPU's read/write requests (address, byte select, write data, read/write enables) and services them against a word-organised RAM array after a configurable number of wait states. It asserts a stall request to the hazard logic while the access is in flight, so the design can be tested with slow-memory timing instead of the zero-wait memory model.

## Interface
Parameters:
- DataWidth, 32, data word width; must be 32 (four byte lanes)
- AddrWidth, 32, byte-address width from the CPU
- DepthLog2, 10, log2 of the number of words in the array
- WaitCycles, 2, stall cycles per access; legal range 1..15

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset: synchronous, active-low
- re  in  1  read request
- we  in  1  write request
- addr_i  in  AddrWidth  byte address
- byte_slct  in  4  write lane enables; bit i covers data[8i+7:8i]
- data_i  in  DataWidth  write data
- data_o  out  DataWidth  read data, valid only in the read completion cycle
- stall_o  out  1  stall request to the hazard control
- ack_o  out  1  one-cycle pulse in the completion cycle of any access
- busy_o  out  1  high while in BUSY

## Operation
- Word index is addr_i[DepthLog2+1:2]. addr_i[1:0] and the bits above DepthLog2+1 are ignored, so addresses alias modulo 4·2^DepthLog2 bytes.
- There are two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
- IDLE with re or we high is a request:
  - latch the word index, data_i, byte_slct and the operation;
  - set cnt to WaitCycles-1;
  - go to BUSY.
- If re and we are both high, the request is a write. The read is dropped and data_o stays 0 for that transaction.
- BUSY with cnt≠0: decrement cnt. Inputs are ignored.
- BUSY with cnt=0 is the completion cycle:
  - ack_o=1;
  - for a read, data_o = array[latched index], combinational;
  - for a write, at the closing edge, each lane with latched byte_slct[i]=1 takes data_i lane i and the other lanes are unchanged;
  - go to IDLE.
- A write with byte_slct=0 modifies nothing but still completes with ack.
- Reads always return the full word; lane extraction and sign extension are done by the CPU.
- Outputs:
  - stall_o = (IDLE and (re or we)) or (BUSY and cnt≠0); forced 0 while rst=0.
  - data_o = 0 outside a read completion cycle.
  - busy_o = (state==BUSY).
- Reset, with rst low at a clock edge:
  - state IDLE, cnt 0;
  - any pending write is discarded and the array is not modified;
  - array contents are not initialised;
  - while rst is low, data_o=0, stall_o=0, ack_o=0, busy_o=0.
- Requests are not queued. The CPU holds its request stable while stall_o is high.

## Timing
- A request first seen in IDLE at cycle T:
  - stall_o is high in cycles T..T+WaitCycles-1;
  - the completion cycle is T+WaitCycles, with stall_o=0 and ack_o=1.
- The next request is sampled no earlier than T+WaitCycles+1. A request held high through the completion cycle is not restarted; the same signal high at T+WaitCycles+1 counts as a new request.
- Back-to-back accesses cost WaitCycles+1 cycles each.
- Written data is visible to a read starting in the cycle after the write completes.
- stall_o has a combinational path from re/we in IDLE only; in BUSY it depends only on state.

## Test plan
- Reset: hold rst=0 for 2 cycles with re=1 → stall_o=0, ack_o=0, data_o=0, busy_o=0.
- Word write/read, WaitCycles=2:
  - write 0xDEADBEEF to 0x10 with slct 4'hF → stall_o high for 2 cycles, ack on the 3rd;
  - read 0x10 → stall_o high for 2 cycles, data_o=0xDEADBEEF only in the ack cycle.
- Byte lanes: write data 0x0000AA00 to 0x10 with slct 4'b0010 → readback 0xDEADAAEF; a write with slct 0 → readback unchanged, ack still pulses.
- Held requests: re held high for 3 consecutive reads of 0x10, 0x14, 0x18 → exactly 3 ack pulses spaced 3 cycles apart, each with the correct word.
- Reset mid-op: start a write of 0x12345678 to 0x20 (old value 0x0), drop rst in the first BUSY cycle, release it, read 0x20 → 0x00000000.
- Aliasing and conflict, DepthLog2=10:
  - read 0x1010 → same word as 0x10;
  - re=we=1 writing 0xCAFEF00D to 0x30 → data_o=0 in the ack cycle, later read of 0x30 returns 0xCAFEF00D.
